// File: rtl/input_ctrl_pkg.sv
// Shared types for input_ctrl: FSM state encoding.
package input_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE         = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_PRESS   = 2'd1;
  localparam logic [STATE_W-1:0] ST_VALID        = 2'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_RELEASE = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    IDLE         = ST_IDLE,
    WAIT_PRESS   = ST_WAIT_PRESS,
    VALID        = ST_VALID,
    WAIT_RELEASE = ST_WAIT_RELEASE
  } state_e;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchroniser followed by a level debouncer with rising-edge pulse.
// Optional feature: INPUT_CTRL_DEBOUNCE_EN builds the stability counter; when
// undefined the debounced level is simply the synchronised input.
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise_c
);

  // Zero stable cycles would make the level follow glitches; refuse to build.
  if (DEBOUNCE_CYCLES == 0) begin : g_cfg_err
    $error("debouncer: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [1:0] sync_q;
  logic       din_s;
  logic       level_d;

  assign din_s = sync_q[1];

  // Metastability guard for the raw pushbutton.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], din};
    end
  end

`ifdef INPUT_CTRL_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             level_q;

  // Count consecutive disagreeing cycles; the final one flips the level, so the
  // counter tops out at DEBOUNCE_CYCLES-1 and can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (din_s == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      level_q <= ~level_q;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign level = level_q;
`else
  assign level = din_s;
`endif

  // Previous level, for 0->1 edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign rise_c = level & ~level_d;

endmodule

// File: rtl/input_ctrl.sv
// Button-confirmed switch input: a consumer requests a word, the user sets the
// switches and presses the button, the captured value is handed over with a
// valid/ack handshake. A held button cannot confirm twice.
// Optional feature: INPUT_CTRL_DEBOUNCE_EN enables button debouncing.
module input_ctrl
  import input_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn,
  input  logic [DATA_WIDTH-1:0] sw,
  input  logic                  req,
  input  logic                  ack,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  waiting
);

  logic [DATA_WIDTH-1:0] sw_s1;
  logic [DATA_WIDTH-1:0] sw_s2;
  logic                  btn_level;
  logic                  press_c;

  state_e                state_q;
  state_e                state_n;
  logic                  valid_n;
  logic                  waiting_n;
  logic [DATA_WIDTH-1:0] data_n;

  // Switches only need synchronising; they are sampled on a debounced press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn),
    .level (btn_level),
    .rise_c(press_c)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_n = state_q;
    data_n  = data;
    case (state_q)
      IDLE: begin
        if (req) state_n = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (press_c) begin
          data_n  = sw_s2;
          state_n = VALID;
        end else if (!req) begin
          state_n = IDLE;
        end
      end
      VALID: begin
        if (ack) state_n = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!btn_level) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    valid_n   = (state_n == VALID);
    waiting_n = (state_n == WAIT_PRESS);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid   <= 1'b0;
      waiting <= 1'b0;
      data    <= '0;
    end else begin
      state_q <= state_n;
      valid   <= valid_n;
      waiting <= waiting_n;
      data    <= data_n;
    end
  end

endmodule

// File: tb/tb_input_ctrl.sv
// Directed bench for input_ctrl (DATA_WIDTH=4, DEBOUNCE_CYCLES=4).
module tb_input_ctrl;

  localparam int unsigned DW = 4;
  localparam int unsigned DB = 4;
`ifdef INPUT_CTRL_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn;
  logic [DW-1:0] sw;
  logic          req;
  logic          ack;
  logic          valid;
  logic [DW-1:0] data;
  logic          waiting;

  int checks = 0;
  int errors = 0;

  input_ctrl #(
    .DATA_WIDTH(DW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .sw(sw),
    .req(req),
    .ack(ack),
    .valid(valid),
    .data(data),
    .waiting(waiting)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; btn = 1'b0; sw = '0; req = 1'b0; ack = 1'b0;
    nclk(3);
    chk("rst_valid", 8'(valid), 8'h0);
    chk("rst_data", 8'(data), 8'h0);
    chk("rst_waiting", 8'(waiting), 8'h0);
    rst_n = 1'b1;
    nclk(2);
    chk("idle_waiting", 8'(waiting), 8'h0);

    // Request, then confirm 4'hA with a held button.
    req = 1'b1; sw = 4'hA;
    nclk(1);
    chk("req_waiting", 8'(waiting), 8'h1);
    chk("req_valid", 8'(valid), 8'h0);
    btn = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      nclk(1);
      chk("pre_press_valid", 8'(valid), 8'h0);
      chk("pre_press_waiting", 8'(waiting), 8'h1);
    end
    nclk(1);
    chk("press_valid", 8'(valid), 8'h1);
    chk("press_data", 8'(data), 8'hA);
    chk("press_waiting", 8'(waiting), 8'h0);

    // req dropping without ack keeps the word offered.
    req = 1'b0;
    nclk(2);
    chk("req_drop_valid", 8'(valid), 8'h1);
    req = 1'b1;
    ack = 1'b1;
    nclk(1);
    ack = 1'b0;
    chk("ack_valid", 8'(valid), 8'h0);
    chk("ack_waiting", 8'(waiting), 8'h0);

    // Held button must not confirm a second time.
    nclk(LAT + 3);
    chk("held_waiting", 8'(waiting), 8'h0);
    chk("held_valid", 8'(valid), 8'h0);
    chk("held_data", 8'(data), 8'hA);
    btn = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      nclk(1);
      chk("release_waiting", 8'(waiting), 8'h0);
    end
    nclk(1);
    chk("rerequest_waiting", 8'(waiting), 8'h1);
    sw = 4'h3;

`ifdef INPUT_CTRL_DEBOUNCE_EN
    // Three-cycle glitch is shorter than the debounce window.
    btn = 1'b1;
    nclk(3);
    btn = 1'b0;
    nclk(LAT + 3);
    chk("glitch_valid", 8'(valid), 8'h0);
    chk("glitch_waiting", 8'(waiting), 8'h1);
`endif

    // Press and req drop land on the same cycle: the press wins.
    btn = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      nclk(1);
`ifndef INPUT_CTRL_DEBOUNCE_EN
      if (k == 1) btn = 1'b0;
`endif
      chk("race_pre_valid", 8'(valid), 8'h0);
      if (k == LAT) req = 1'b0;
    end
    nclk(1);
    chk("race_valid", 8'(valid), 8'h1);
    chk("race_data", 8'(data), 8'h3);
    ack = 1'b1;
    nclk(1);
    ack = 1'b0;
    btn = 1'b0;
    chk("race_ack_valid", 8'(valid), 8'h0);
    nclk(LAT + 4);

    // ack outside VALID is ignored.
    ack = 1'b1;
    nclk(1);
    ack = 1'b0;
    nclk(1);
    chk("stray_ack_valid", 8'(valid), 8'h0);
    chk("stray_ack_waiting", 8'(waiting), 8'h0);

    // Press in IDLE is forgotten.
    sw = 4'h7;
    btn = 1'b1;
    nclk(LAT + 3);
    btn = 1'b0;
    nclk(LAT + 3);
    chk("idle_press_valid", 8'(valid), 8'h0);
    req = 1'b1;
    nclk(1);
    chk("stale_waiting", 8'(waiting), 8'h1);
    chk("stale_valid", 8'(valid), 8'h0);
    chk("stale_data", 8'(data), 8'h3);
    nclk(LAT + 2);
    chk("stale_valid_later", 8'(valid), 8'h0);

    // Async reset while VALID with data 5.
    sw = 4'h5;
    btn = 1'b1;
    nclk(LAT + 1);
    chk("pre_rst_valid", 8'(valid), 8'h1);
    chk("pre_rst_data", 8'(data), 8'h5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 8'(valid), 8'h0);
    chk("async_rst_data", 8'(data), 8'h0);
    chk("async_rst_waiting", 8'(waiting), 8'h0);
    btn = 1'b0; req = 1'b0;
    nclk(2);
    rst_n = 1'b1;
    nclk(2);
    chk("post_rst_valid", 8'(valid), 8'h0);
    chk("post_rst_waiting", 8'(waiting), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
